// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding program-memory requester feeding a
// prefetch queue, with redirect flush, drain of in-flight reads and end-of-program halt.
module instruction_fetch_unit #(
   parameter int unsigned                  INSTR_ADDR_WIDTH = 8,
   parameter int unsigned                  DEPTH            = 4,
   parameter logic [INSTR_ADDR_WIDTH-1:0]  RESET_WORD       = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        E,
   output logic                        mem_req,
   output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
   input  logic                        mem_ack,
   input  logic [31:0]                 mem_rdata,
   input  logic                        redirect,
   input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [31:0]                 instr,
   output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
   output logic [$clog2(DEPTH):0]      level,
   output logic                        pc_end
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned AW    = INSTR_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [AW-1:0]     fetch_pc;
   logic [AW-1:0]     fetch_pc_nxt;
   logic [AW-1:0]     drain_addr;
   logic [AW-1:0]     drain_addr_nxt;
   logic              push;
   logic              flush;
   logic              pop;
   logic              last_word;
   logic              slot_now;
   logic              slot_after_push;
   logic [LVL_W-1:0]  level_after_pop;

   logic [31:0]       data_q [DEPTH];
   logic [AW-1:0]     pc_q   [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   assign instr_valid     = (level != '0);
   assign pop             = instr_valid && instr_ready;
   assign level_after_pop = level - LVL_W'(pop);
   assign slot_now        = level_after_pop < LVL_W'(DEPTH);
   assign slot_after_push = (level_after_pop + LVL_W'(1)) < LVL_W'(DEPTH);
   assign last_word       = (fetch_pc == {AW{1'b1}});

   // DRAIN presents the abandoned request's address until its ack retires it
   assign mem_req  = (state == REQ) || (state == DRAIN);
   assign mem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
   assign pc_end   = (state == HALT) && (level == '0);
   assign instr    = data_q[rd_ptr];
   assign instr_pc = pc_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         fetch_pc   <= RESET_WORD;
         drain_addr <= RESET_WORD;
      end else begin
         state      <= state_nxt;
         fetch_pc   <= fetch_pc_nxt;
         drain_addr <= drain_addr_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      fetch_pc_nxt   = fetch_pc;
      drain_addr_nxt = drain_addr;
      push           = 1'b0;
      flush          = 1'b0;
      if (redirect) begin
         flush        = 1'b1;
         fetch_pc_nxt = redirect_pc;
         unique case (state)
            REQ: begin
               if (mem_ack) begin
                  state_nxt = E ? REQ : IDLE;
               end else begin
                  state_nxt      = DRAIN;
                  drain_addr_nxt = fetch_pc;
               end
            end
            // an ack arriving with the redirect retires the stale read, nothing left to drain
            DRAIN:   state_nxt = mem_ack ? (E ? REQ : IDLE) : DRAIN;
            default: state_nxt = E ? REQ : IDLE;
         endcase
      end else begin
         unique case (state)
            IDLE: begin
               if (E && slot_now) state_nxt = REQ;
            end
            REQ: begin
               if (mem_ack) begin
                  push = 1'b1;
                  if (last_word) begin
                     state_nxt = HALT;
                  end else begin
                     fetch_pc_nxt = fetch_pc + AW'(1);
                     state_nxt    = (E && slot_after_push) ? REQ : IDLE;
                  end
               end
            end
            DRAIN: begin
               if (mem_ack) state_nxt = E ? REQ : IDLE;
            end
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // queue pointers and occupancy; a redirect empties the queue outright
   always_ff @(posedge clk) begin
      if (!rst) begin
         level  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (flush) begin
         level  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         level <= level_after_pop + LVL_W'(push);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr] <= mem_rdata;
         pc_q[wr_ptr]   <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed fetch, backpressure,
// redirect/drain, halt and reset scenarios against a wait-state memory model.
module tb_instruction_fetch_unit;

   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          E;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [31:0]   mem_rdata;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic [31:0]   instr;
   logic [AW-1:0] instr_pc;
   logic [2:0]    level;
   logic          pc_end;

   int            checks = 0;
   int            failures = 0;
   int            waits = 0;
   int            wait_cnt = 0;
   logic          ack_force = 1'b0;
   logic [39:0]   sb[$];
   logic          prev_pending = 1'b0;
   logic [AW-1:0] prev_addr = '0;

   instruction_fetch_unit #(.INSTR_ADDR_WIDTH(AW), .DEPTH(4), .RESET_WORD(8'h00)) dut (
      .clk(clk), .rst(rst), .E(E),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
      .level(level), .pc_end(pc_end)
   );

   always #5 clk = ~clk;

   // memory: tagged word per address, ack after 'waits' request cycles
   assign mem_rdata = 32'hC0DE_0000 | {24'h0, mem_addr};
   assign mem_ack   = ack_force | (mem_req && (wait_cnt == waits));

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
   end

   function automatic logic [39:0] entry(input logic [AW-1:0] pc);
      return {pc, 32'hC0DE_0000 | {24'h0, pc}};
   endfunction

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; E = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      step(2);
      rst = 1'b1;
   endtask

   // monitor: consumed instructions against the scoreboard, request address stability
   always @(negedge clk) begin
      if (rst && instr_valid && instr_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_pop", {instr_pc, instr}, 40'h0);
         end else begin
            check("pop_entry", {instr_pc, instr}, sb.pop_front());
         end
      end
      if (rst && prev_pending) begin
         check("req_held", 40'(mem_req), 40'd1);
         check("addr_stable", 40'(mem_addr), 40'(prev_addr));
      end
      prev_pending = rst && mem_req && !mem_ack;
      prev_addr    = mem_addr;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; E = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      step(2);
      check("rst_mem_req", 40'(mem_req), 40'd0);
      check("rst_valid", 40'(instr_valid), 40'd0);
      check("rst_level", 40'(level), 40'd0);
      check("rst_pc_end", 40'(pc_end), 40'd0);

      // zero-wait memory, continuous consumer: one instruction per cycle
      waits = 0; instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) sb.push_back(entry(AW'(i)));
      rst = 1'b1; E = 1'b1;
      step(1);
      check("first_req", 40'(mem_req), 40'd1);
      check("first_addr", 40'(mem_addr), 40'h00);
      for (int i = 0; i < 7; i++) begin
         step(1);
         check("stream_level_le1", 40'(level <= 3'd1), 40'd1);
      end
      E = 1'b0;
      step(2);
      check("stream_done", 40'(sb.size()), 40'd0);
      check("stream_level0", 40'(level), 40'd0);
      check("stream_idle", 40'(mem_req), 40'd0);

      // stalled consumer with 3 wait states fills the queue
      do_reset();
      waits = 3;
      for (int i = 0; i < 5; i++) sb.push_back(entry(AW'(i)));
      E = 1'b1;
      for (int i = 0; i < 60 && level != 3'd4; i++) step(1);
      check("full_level", 40'(level), 40'd4);
      check("full_no_req", 40'(mem_req), 40'd0);
      check("full_head", {instr_pc, instr}, entry(8'h00));
      instr_ready = 1'b1;
      step(1);
      instr_ready = 1'b0;
      check("refill_req", 40'(mem_req), 40'd1);
      check("refill_addr", 40'(mem_addr), 40'h04);
      E = 1'b0;
      step(1);
      check("e_drop_hold", 40'(mem_req), 40'd1);
      for (int i = 0; i < 10 && level != 3'd4; i++) step(1);
      check("refill_level", 40'(level), 40'd4);
      check("refill_idle", 40'(mem_req), 40'd0);
      instr_ready = 1'b1;
      for (int i = 0; i < 10 && level != 3'd0; i++) step(1);
      check("bp_done", 40'(sb.size()), 40'd0);

      // redirect while a request is pending: drain the stale read
      do_reset();
      waits = 4; instr_ready = 1'b1; E = 1'b1;
      redirect = 1'b1; redirect_pc = 8'h05;
      step(1);
      redirect = 1'b0;
      check("r5_addr", 40'(mem_addr), 40'h05);
      step(1);
      redirect = 1'b1; redirect_pc = 8'h20;
      step(1);
      redirect = 1'b0;
      check("drain_req", 40'(mem_req), 40'd1);
      check("drain_addr", 40'(mem_addr), 40'h05);
      check("drain_level", 40'(level), 40'd0);
      sb.push_back(entry(8'h20));
      for (int i = 0; i < 10 && mem_addr == 8'h05; i++) step(1);
      check("post_drain_req", 40'(mem_req), 40'd1);
      check("post_drain_addr", 40'(mem_addr), 40'h20);
      E = 1'b0;
      for (int i = 0; i < 12 && sb.size() != 0; i++) step(1);
      step(1);
      check("drain_done", 40'(sb.size()), 40'd0);
      check("drain_idle", 40'(mem_req), 40'd0);

      // redirect in the ack cycle: acked data dropped, no drain
      do_reset();
      waits = 0; E = 1'b1;
      step(1);
      redirect = 1'b1; redirect_pc = 8'h40;
      step(1);
      redirect = 1'b0;
      check("rack_level", 40'(level), 40'd0);
      check("rack_req", 40'(mem_req), 40'd1);
      check("rack_addr", 40'(mem_addr), 40'h40);
      E = 1'b0;
      step(1);
      check("rack_level1", 40'(level), 40'd1);
      check("rack_head", {instr_pc, instr}, entry(8'h40));
      sb.push_back(entry(8'h40));
      instr_ready = 1'b1;
      step(2);
      check("rack_done", 40'(sb.size()), 40'd0);

      // run off the end of program memory into HALT
      do_reset();
      waits = 0; E = 1'b1;
      redirect = 1'b1; redirect_pc = 8'hFD;
      step(1);
      redirect = 1'b0;
      sb.push_back(entry(8'hFD)); sb.push_back(entry(8'hFE)); sb.push_back(entry(8'hFF));
      for (int i = 0; i < 10 && level != 3'd3; i++) step(1);
      check("halt_level", 40'(level), 40'd3);
      check("halt_pc_end_busy", 40'(pc_end), 40'd0);
      step(2);
      check("halt_no_req", 40'(mem_req), 40'd0);
      instr_ready = 1'b1;
      for (int i = 0; i < 10 && level != 3'd0; i++) step(1);
      check("halt_pc_end", 40'(pc_end), 40'd1);
      redirect = 1'b1; redirect_pc = 8'h10;
      step(1);
      redirect = 1'b0;
      check("resume_pc_end", 40'(pc_end), 40'd0);
      check("resume_req", 40'(mem_req), 40'd1);
      check("resume_addr", 40'(mem_addr), 40'h10);
      sb.push_back(entry(8'h10));
      E = 1'b0;
      for (int i = 0; i < 10 && sb.size() != 0; i++) step(1);
      check("resume_done", 40'(sb.size()), 40'd0);

      // reset during DRAIN, late ack must be ignored
      do_reset();
      waits = 20; instr_ready = 1'b1; E = 1'b1;
      redirect = 1'b1; redirect_pc = 8'h30;
      step(1);
      redirect_pc = 8'h50;
      step(1);
      redirect = 1'b0;
      check("rd_drain_addr", 40'(mem_addr), 40'h30);
      rst = 1'b0;
      step(1);
      ack_force = 1'b1;
      step(1);
      rst = 1'b1; E = 1'b0;
      step(1);
      ack_force = 1'b0;
      check("rd_req", 40'(mem_req), 40'd0);
      check("rd_level", 40'(level), 40'd0);
      check("rd_valid", 40'(instr_valid), 40'd0);
      check("rd_pc_end", 40'(pc_end), 40'd0);
      waits = 0; E = 1'b1;
      sb.push_back(entry(8'h00));
      step(1);
      check("rd_restart_addr", 40'(mem_addr), 40'h00);
      E = 1'b0;
      step(3);
      check("rd_done", 40'(sb.size()), 40'd0);
      check("rd_final_level", 40'(level), 40'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
